cache_axi_arbiter: RTL and testbench
====================================

# cache_axi_arbiter

Shares one AXI4 master port between the instruction cache and the data cache. The arbiter accepts read-refill requests from both caches and write-back requests from the data cache, converts them into AXI bursts, and returns refill data beat by beat to the requester that owns the read. It sits between the two `cache` instances and the SoC AXI crossbar, and is the only AXI master in the CPU.

## Interface
- No parameters. AXI data width is 32, the ID width is 4, and a line is 16 bytes (4 beats).
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `ic_rd_req` / `dc_rd_req` in 1: read request. It is held until the matching `*_rd_rdy` is seen.
- `ic_rd_type` / `dc_rd_type` in 3: `3'b100` is a 4-beat line; `3'b010` is a single word.
- `ic_rd_addr` / `dc_rd_addr` in 32: byte address. For line requests it is 16-byte aligned.
- `ic_rd_rdy` / `dc_rd_rdy` out 1: combinational grant. The request is accepted in this cycle.
- `ic_ret_valid` / `dc_ret_valid` out 1: the refill beat is valid.
- `ic_ret_last` / `dc_ret_last` out 1: the final beat of the refill.
- `ic_ret_data` / `dc_ret_data` out 32: refill beat data.
- `dc_wr_req` in 1: write request.
- `dc_wr_type` in 3: same encoding as `rd_type`.
- `dc_wr_addr` in 32: write byte address.
- `dc_wr_strb` in 4: byte strobe for word writes.
- `dc_wr_data` in 128: line data; beat *k* is `[32k+31:32k]`.
- `dc_wr_rdy` out 1: the write buffer is free and the request is accepted.
- `arid` out 4; `araddr` out 32; `arlen` out 8; `arsize` out 3; `arburst` out 2; `arvalid` out 1; `arready` in 1.
- `rid` in 4; `rdata` in 32; `rresp` in 2; `rlast` in 1; `rvalid` in 1; `rready` out 1.
- `awid` out 4; `awaddr` out 32; `awlen` out 8; `awsize` out 3; `awburst` out 2; `awvalid` out 1; `awready` in 1.
- `wid` out 4; `wdata` out 32; `wstrb` out 4; `wlast` out 1; `wvalid` out 1; `wready` in 1.
- `bid` in 4; `bresp` in 2; `bvalid` in 1; `bready` out 1.
- `arlock`/`arcache`/`arprot` and `awlock`/`awcache`/`awprot` out 2/4/3 each: tied to 0.

## Operation
- **Read FSM** has states RD_IDLE, RD_AR and RD_DATA. At most one read is outstanding.
  - RD_IDLE:
    - Grant goes to the dcache if `dc_rd_req` is eligible, otherwise to the icache (fixed priority).
    - Grant latches address, type and owner, and the FSM moves to RD_AR.
  - RD_AR:
    - `arvalid`=1, with `arid` = 0 for icache and 1 for dcache.
    - Line request: `arlen`=3. Word request: `arlen`=0. Always `arsize`=2 and `arburst`=INCR (01).
    - Handshake moves the FSM to RD_DATA.
  - RD_DATA:
    - `rready`=1.
    - Each `rvalid` beat is forwarded to the owner's `ret_*` in the same cycle (combinational pass-through).
    - `ret_last` = `rlast`.
    - A beat with `rlast` returns the FSM to RD_IDLE.
  - `rresp` is ignored.
- **Write FSM** has states WR_IDLE, WR_AW, WR_DATA and WR_RESP.
  - `dc_wr_rdy`=1 only in WR_IDLE. Acceptance latches addr/type/strb/data into a 128-bit buffer and moves to WR_AW.
  - WR_AW:
    - `awvalid`=1, `awid`=1.
    - Line request: `awlen`=3. Word request: `awlen`=0.
    - The FSM moves to WR_DATA on handshake.
  - WR_DATA:
    - `wvalid`=1, `wid`=1.
    - `wdata` = buffer beat at a 2-bit beat counter.
    - `wstrb` = 1111 for a line, or the latched strb for a word.
    - `wlast` is set on beat 3 for a line, or beat 0 for a word.
    - Each handshake increments the counter. A handshake with `wlast` moves to WR_RESP.
  - WR_RESP: `bready`=1. `bvalid` returns the FSM to WR_IDLE.
- **RAW hazard:** `dc_rd_req` is ineligible while the write FSM is not in WR_IDLE and `dc_rd_addr[31:4]` == buffered `wr_addr[31:4]`. The icache is not checked.
- A read and a write may be accepted in the same cycle; the two FSMs are independent.

## Timing
- The grant (`rd_rdy`/`wr_rdy`) is combinational in cycle *t*. `arvalid`/`awvalid` rise at *t*+1.
- `arvalid`, `awvalid` and `wvalid` hold stable with their payload until their ready is seen.
- Beat latency from `rvalid` to `ret_valid` is 0 cycles.
- The minimum line refill is 1 (AR) + 4 (R) cycles after grant. The next grant is possible in the cycle after `rlast`.
- Reset (asynchronous, any cycle including mid-burst):
  - Both FSMs go to IDLE.
  - All `*valid`, `rready`, `bready`, `ret_valid` and `ret_last` become 0.
  - `rd_rdy`=0 and `wr_rdy`=1.
  - Address and data outputs become 0.
  - The beat counter becomes 0.
  - An in-flight burst is abandoned; the system resets the interconnect together with the arbiter.

## Structure
- Shared header `mycpu_head.h`: rd/wr type codes, AXI burst/size constants, AXI IDs, and FSM state encodings.
- Natural sub-module: `axi_wr_channel` (write FSM plus line buffer). The read side stays inline.

## Test plan
- icache line read at 0x1C00_0000, `arready` 2 cycles late, then 4 R beats 0xA0..0xA3 → `arlen`=3 and `arid`=0; `ic_ret_data` A0..A3 with `ret_last` on A3; dcache sees no `ret_valid`.
- `ic_rd_req` and `dc_rd_req` in the same cycle → `dc_rd_rdy`=1 and `ic_rd_rdy`=0; the icache is granted the cycle after the dcache `rlast`.
- dcache line write to 0x0000_1230 with data {D3,D2,D1,D0}, `wready` toggling → W beats D0..D3, `wstrb` 1111, `wlast` on D3 only; `wr_rdy` returns after `bvalid`.
- Word write with strb 0110 → `awlen`=0, a single beat with `wstrb`=0110 and `wlast`=1.
- Pending write to 0x0000_1230 plus dcache read of 0x0000_1238 → no grant until the cycle after `bvalid`. A read of 0x0000_2000 is granted immediately.
- Assert `resetn`=0 in the middle of the R burst → all valids drop asynchronously; after release, a fresh icache read completes normally.

Source files
------------

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared constants and types for the cache-to-AXI arbiter slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: request type codes, AXI burst/size/len constants, AXI IDs,
// read/write FSM state encodings and the latched read-request record.
package cache_axi_arbiter_pkg;

  localparam logic [2:0] REQ_LINE = 3'b100;  // 4-beat, 16-byte line
  localparam logic [2:0] REQ_WORD = 3'b010;  // single 32-bit word

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [7:0] AXI_LEN_LINE   = 8'd3;
  localparam logic [7:0] AXI_LEN_WORD   = 8'd0;

  localparam logic [3:0] AXI_ID_IC = 4'd0;
  localparam logic [3:0] AXI_ID_DC = 4'd1;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW   = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_e;

  // Read request captured at grant time; owner_dc selects the return port.
  typedef struct packed {
    logic [31:0] addr;
    logic        line;
    logic        owner_dc;
  } rd_req_t;

  function automatic logic [7:0] burst_len(input logic line);
    return line ? AXI_LEN_LINE : AXI_LEN_WORD;
  endfunction

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// AXI4 master bus between the cache arbiter and the SoC crossbar.
// Latency: n/a (wiring only).
// Backpressure: standard AXI valid/ready on every channel.
// Modports: master = arbiter side (drives AR/AW/W, rready, bready);
//           slave  = interconnect side (drives ready/R/B).
interface cache_axi_arbiter_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cache_axi_arbiter_axi_wr_channel.sv
// Data-cache write-back engine: buffers one line/word and drives AW, W, B.
// Latency: awvalid one cycle after acceptance; one W beat per wready cycle.
// Backpressure: wr_rdy only in WR_IDLE; AW/W hold payload until ready.
// Ports: wr_* request from dcache; busy/buf_line expose the pending address
// for the read-after-write check; aw*/w*/b* connect to the AXI bus.
module axi_wr_channel
  import cache_axi_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_strb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         busy,
  output logic [27:0]  buf_line,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  wr_state_e     state, state_nxt;
  logic [31:0]   addr_q;
  logic          line_q;
  logic [3:0]    strb_q;
  logic [127:0]  data_q;
  logic [1:0]    beat_q;
  logic          accept;

  assign accept = wr_req && (state == WR_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= WR_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WR_IDLE: if (wr_req)          state_nxt = WR_AW;
      WR_AW:   if (awready)         state_nxt = WR_DATA;
      WR_DATA: if (wready && wlast) state_nxt = WR_RESP;
      WR_RESP: if (bvalid)          state_nxt = WR_IDLE;
      default:                      state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      line_q <= 1'b0;
      strb_q <= '0;
      data_q <= '0;
      beat_q <= '0;
    end else if (accept) begin
      addr_q <= wr_addr;
      line_q <= (wr_type == REQ_LINE);
      strb_q <= wr_strb;
      data_q <= wr_data;
      beat_q <= '0;
    end else if (wvalid && wready) begin
      beat_q <= beat_q + 2'd1;
    end
  end

  always_comb begin
    wr_rdy  = (state == WR_IDLE);
    awvalid = (state == WR_AW);
    wvalid  = (state == WR_DATA);
    bready  = (state == WR_RESP);
    awaddr  = addr_q;
    awlen   = burst_len(line_q);
    wdata   = data_q[{beat_q, 5'd0} +: 32];
    // Line bursts write every byte; word writes keep the caller's byte mask.
    wstrb   = line_q ? 4'hF : strb_q;
    wlast   = wvalid && (beat_q == (line_q ? 2'd3 : 2'd0));
  end

  assign busy     = (state != WR_IDLE);
  assign buf_line = addr_q[31:4];

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares the single AXI4 master between icache refills and dcache refill/write-back.
// Latency: grant combinational; arvalid next cycle; R beats forwarded in the same cycle.
// Backpressure: one outstanding read; dcache wins ties; dcache reads to a line
// still held in the write buffer wait until the write response arrives.
// Ports: clk/resetn; ic_rd_*/ic_ret_* icache; dc_rd_*/dc_ret_*/dc_wr_* dcache; axi = AXI4 master.
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         ic_rd_req,
  input  logic [2:0]   ic_rd_type,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_rd_rdy,
  output logic         ic_ret_valid,
  output logic         ic_ret_last,
  output logic [31:0]  ic_ret_data,
  input  logic         dc_rd_req,
  input  logic [2:0]   dc_rd_type,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  output logic         dc_ret_valid,
  output logic         dc_ret_last,
  output logic [31:0]  dc_ret_data,
  input  logic         dc_wr_req,
  input  logic [2:0]   dc_wr_type,
  input  logic [31:0]  dc_wr_addr,
  input  logic [3:0]   dc_wr_strb,
  input  logic [127:0] dc_wr_data,
  output logic         dc_wr_rdy,
  cache_axi_arbiter_if.master axi
);

  rd_state_e   rd_state, rd_state_nxt;
  rd_req_t     rd_q;
  logic        wr_busy;
  logic [27:0] wr_buf_line;
  logic        dc_eligible, grant_dc, grant_ic, rd_data_phase, r_beat;
  logic        unused_resp;

  // A dcache read of the line still in the write buffer would see stale memory.
  assign dc_eligible = dc_rd_req && !(wr_busy && (dc_rd_addr[31:4] == wr_buf_line));
  // Grants are masked by resetn so nothing is accepted while reset is held.
  assign grant_dc    = resetn && (rd_state == RD_IDLE) && dc_eligible;
  assign grant_ic    = resetn && (rd_state == RD_IDLE) && ic_rd_req && !dc_eligible;
  assign dc_rd_rdy   = grant_dc;
  assign ic_rd_rdy   = grant_ic;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_state <= RD_IDLE;
    else         rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (grant_dc || grant_ic)         rd_state_nxt = RD_AR;
      RD_AR:   if (axi.arready)                  rd_state_nxt = RD_DATA;
      RD_DATA: if (axi.rvalid && axi.rlast)      rd_state_nxt = RD_IDLE;
      default:                                   rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q <= '0;
    end else if (grant_dc) begin
      rd_q <= '{addr: dc_rd_addr, line: (dc_rd_type == REQ_LINE), owner_dc: 1'b1};
    end else if (grant_ic) begin
      rd_q <= '{addr: ic_rd_addr, line: (ic_rd_type == REQ_LINE), owner_dc: 1'b0};
    end
  end

  assign rd_data_phase = (rd_state == RD_DATA);
  assign r_beat        = rd_data_phase && axi.rvalid;

  always_comb begin
    axi.arvalid = (rd_state == RD_AR);
    axi.araddr  = rd_q.addr;
    axi.arid    = rd_q.owner_dc ? AXI_ID_DC : AXI_ID_IC;
    axi.arlen   = burst_len(rd_q.line);
    axi.arsize  = AXI_SIZE_4B;
    axi.arburst = AXI_BURST_INCR;
    axi.rready  = rd_data_phase;
  end

  // Refill beats pass straight through to whichever cache owns the read.
  assign ic_ret_valid = r_beat && !rd_q.owner_dc;
  assign dc_ret_valid = r_beat &&  rd_q.owner_dc;
  assign ic_ret_last  = ic_ret_valid && axi.rlast;
  assign dc_ret_last  = dc_ret_valid && axi.rlast;
  assign ic_ret_data  = ic_ret_valid ? axi.rdata : '0;
  assign dc_ret_data  = dc_ret_valid ? axi.rdata : '0;

  // Error responses and returned IDs carry no information for this master.
  assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

  axi_wr_channel u_wr (
    .clk      (clk),
    .resetn   (resetn),
    .wr_req   (dc_wr_req),
    .wr_type  (dc_wr_type),
    .wr_addr  (dc_wr_addr),
    .wr_strb  (dc_wr_strb),
    .wr_data  (dc_wr_data),
    .wr_rdy   (dc_wr_rdy),
    .busy     (wr_busy),
    .buf_line (wr_buf_line),
    .awaddr   (axi.awaddr),
    .awlen    (axi.awlen),
    .awvalid  (axi.awvalid),
    .awready  (axi.awready),
    .wdata    (axi.wdata),
    .wstrb    (axi.wstrb),
    .wlast    (axi.wlast),
    .wvalid   (axi.wvalid),
    .wready   (axi.wready),
    .bvalid   (axi.bvalid),
    .bready   (axi.bready)
  );

  assign axi.awid    = AXI_ID_DC;
  assign axi.wid     = AXI_ID_DC;
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Bench for cache_axi_arbiter: directed stimulus, scoreboard queues, negedge monitors.
// Latency: expects AR/AW one cycle after grant, R beats forwarded same cycle.
// Backpressure: exercises late arready, toggling wready, RAW blocking and mid-burst reset.
module tb_cache_axi_arbiter;

  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [31:0] data; logic last; } ret_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ic_rd_req, dc_rd_req, dc_wr_req;
  logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
  logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic [3:0]   dc_wr_strb;
  logic [127:0] dc_wr_data;
  logic         ic_rd_rdy, dc_rd_rdy, dc_wr_rdy;
  logic         ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last;
  logic [31:0]  ic_ret_data, dc_ret_data;
  logic         rdy_b;

  int checks = 0;
  int failures = 0;

  ax_t  exp_ar[$], exp_aw[$];
  w_t   exp_w[$];
  ret_t exp_ic[$], exp_dc[$];
  ax_t  ea, eaw;
  w_t   ew;
  ret_t er;

  cache_axi_arbiter_if axi();

  cache_axi_arbiter dut (
    .clk(clk), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_strb(dc_wr_strb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ax_t mk_ax(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    ax_t r;
    r.id = id; r.addr = addr; r.len = len;
    return r;
  endfunction

  function automatic ret_t mk_ret(input logic [31:0] data, input logic last);
    ret_t r;
    r.data = data; r.last = last;
    return r;
  endfunction

  function automatic w_t mk_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    w_t r;
    r.data = data; r.strb = strb; r.last = last;
    return r;
  endfunction

  // Monitors: every handshake or return beat pops one expected entry.
  always @(negedge clk) begin
    if (axi.arvalid && axi.arready) begin
      if (exp_ar.size() == 0) begin
        checks++; failures++;
        $display("FAIL ar_unexpected: got addr %0h expected no AR", axi.araddr);
      end else begin
        ea = exp_ar.pop_front();
        chk("ar_id", axi.arid, ea.id);
        chk("ar_addr", axi.araddr, ea.addr);
        chk("ar_len", axi.arlen, ea.len);
        chk("ar_size_burst", {axi.arsize, axi.arburst}, {3'd2, 2'b01});
      end
    end
    if (axi.awvalid && axi.awready) begin
      if (exp_aw.size() == 0) begin
        checks++; failures++;
        $display("FAIL aw_unexpected: got addr %0h expected no AW", axi.awaddr);
      end else begin
        eaw = exp_aw.pop_front();
        chk("aw_id", axi.awid, eaw.id);
        chk("aw_addr", axi.awaddr, eaw.addr);
        chk("aw_len", axi.awlen, eaw.len);
        chk("aw_size_burst", {axi.awsize, axi.awburst}, {3'd2, 2'b01});
      end
    end
    if (axi.wvalid && axi.wready) begin
      if (exp_w.size() == 0) begin
        checks++; failures++;
        $display("FAIL w_unexpected: got data %0h expected no W", axi.wdata);
      end else begin
        ew = exp_w.pop_front();
        chk("w_data", axi.wdata, ew.data);
        chk("w_strb", axi.wstrb, ew.strb);
        chk("w_last", axi.wlast, ew.last);
        chk("w_id", axi.wid, 4'd1);
      end
    end
    if (ic_ret_valid) begin
      if (exp_ic.size() == 0) begin
        checks++; failures++;
        $display("FAIL ic_ret_unexpected: got data %0h expected no beat", ic_ret_data);
      end else begin
        er = exp_ic.pop_front();
        chk("ic_ret_data", ic_ret_data, er.data);
        chk("ic_ret_last", ic_ret_last, er.last);
      end
    end
    if (dc_ret_valid) begin
      if (exp_dc.size() == 0) begin
        checks++; failures++;
        $display("FAIL dc_ret_unexpected: got data %0h expected no beat", dc_ret_data);
      end else begin
        er = exp_dc.pop_front();
        chk("dc_ret_data", dc_ret_data, er.data);
        chk("dc_ret_last", dc_ret_last, er.last);
      end
    end
  end

  task automatic ar_accept(input int delay);
    for (int i = 0; i < 20 && !axi.arvalid; i++) tick();
    chk("ar_wait", axi.arvalid, 1'b1);
    repeat (delay) begin
      @(negedge clk); chk("arvalid_hold", axi.arvalid, 1'b1);
      tick();
    end
    axi.arready = 1'b1;
    @(negedge clk);
    tick();
    axi.arready = 1'b0;
  endtask

  task automatic aw_accept();
    for (int i = 0; i < 20 && !axi.awvalid; i++) tick();
    chk("aw_wait", axi.awvalid, 1'b1);
    axi.awready = 1'b1;
    @(negedge clk);
    tick();
    axi.awready = 1'b0;
  endtask

  // Drives n R beats with data base+k; rlast on beat len-1.
  task automatic rd_burst(input logic own_dc, input logic [31:0] base, input int n, input int len);
    for (int k = 0; k < n; k++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = base + k;
      axi.rlast  = (k == len - 1);
      axi.rid    = {3'b000, own_dc};
      axi.rresp  = (k == 1) ? 2'b10 : 2'b00;
      if (own_dc) exp_dc.push_back(mk_ret(base + k, k == len - 1));
      else        exp_ic.push_back(mk_ret(base + k, k == len - 1));
      @(negedge clk);
      chk("rready", axi.rready, 1'b1);
      chk("rd_rdy_busy", {ic_rd_rdy, dc_rd_rdy}, 2'b00);
      tick();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  task automatic wr_issue(input logic line, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [127:0] data);
    int nb;
    nb = line ? 4 : 1;
    dc_wr_req  = 1'b1;
    dc_wr_type = line ? 3'b100 : 3'b010;
    dc_wr_addr = addr;
    dc_wr_strb = strb;
    dc_wr_data = data;
    exp_aw.push_back(mk_ax(4'd1, addr, line ? 8'd3 : 8'd0));
    for (int k = 0; k < nb; k++)
      exp_w.push_back(mk_w(data[32*k +: 32], line ? 4'hF : strb, k == nb - 1));
    @(negedge clk);
    chk("wr_rdy_idle", dc_wr_rdy, 1'b1);
    tick();
    dc_wr_req = 1'b0;
  endtask

  task automatic w_drain(input int n, input bit toggle);
    int got;
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      axi.wready = toggle ? c[0] : 1'b1;
      @(negedge clk);
      if (axi.wvalid && axi.wready) got++;
      tick();
    end
    axi.wready = 1'b0;
    chk("w_beats", got, n);
  endtask

  task automatic b_accept(output logic rd_rdy_seen);
    axi.bvalid = 1'b1;
    axi.bid    = 4'd1;
    axi.bresp  = 2'b00;
    @(negedge clk);
    chk("bready", axi.bready, 1'b1);
    chk("wr_rdy_resp", dc_wr_rdy, 1'b0);
    rd_rdy_seen = dc_rd_rdy;
    tick();
    axi.bvalid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0000;
    dc_rd_req = 1'b1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_3000;
    dc_wr_req = 1'b0; dc_wr_type = 3'b000; dc_wr_addr = '0; dc_wr_strb = '0; dc_wr_data = '0;
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;

    // Reset state, with requests pending to show grants are blocked.
    repeat (2) tick();
    @(negedge clk);
    chk("rst_rd_rdy", {ic_rd_rdy, dc_rd_rdy}, 2'b00);
    chk("rst_wr_rdy", dc_wr_rdy, 1'b1);
    chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'd0);
    chk("rst_ret", {ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last}, 4'd0);
    chk("rst_addr_data", {axi.araddr, axi.awaddr, axi.wdata}, 96'd0);
    chk("rst_ties", {axi.arlock, axi.arcache, axi.arprot, axi.awlock, axi.awcache, axi.awprot}, 18'd0);
    tick();
    ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    resetn = 1'b1;
    tick();

    // 1: icache line read, arready two cycles late, beats A0..A3.
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0000;
    exp_ar.push_back(mk_ax(4'd0, 32'h1C00_0000, 8'd3));
    @(negedge clk);
    chk("t1_ic_rdy", ic_rd_rdy, 1'b1);
    tick(); ic_rd_req = 1'b0;
    ar_accept(2);
    rd_burst(1'b0, 32'hA0, 4, 4);

    // 2: simultaneous requests; dcache first, icache the cycle after rlast.
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0040;
    dc_rd_req = 1'b1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_3000;
    exp_ar.push_back(mk_ax(4'd1, 32'h0000_3000, 8'd3));
    @(negedge clk);
    chk("t2_grant", {ic_rd_rdy, dc_rd_rdy}, 2'b01);
    tick(); dc_rd_req = 1'b0;
    ar_accept(0);
    rd_burst(1'b1, 32'hB0, 4, 4);
    @(negedge clk);
    chk("t2_ic_after_rlast", ic_rd_rdy, 1'b1);
    exp_ar.push_back(mk_ax(4'd0, 32'h1C00_0040, 8'd3));
    tick(); ic_rd_req = 1'b0;
    ar_accept(0);
    rd_burst(1'b0, 32'hC0, 4, 4);

    // 3: dcache line write, wready toggling.
    wr_issue(1'b1, 32'h0000_1230, 4'h0,
             {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000});
    @(negedge clk);
    chk("t3_wr_busy", dc_wr_rdy, 1'b0);
    tick();
    aw_accept();
    w_drain(4, 1'b1);
    b_accept(rdy_b);
    @(negedge clk);
    chk("t3_wr_rdy_back", dc_wr_rdy, 1'b1);
    tick();

    // 4: word write with a partial strobe.
    wr_issue(1'b0, 32'h0000_4004, 4'b0110, {96'd0, 32'h1234_5678});
    aw_accept();
    w_drain(1, 1'b0);
    b_accept(rdy_b);
    @(negedge clk);
    chk("t4_wr_rdy_back", dc_wr_rdy, 1'b1);
    tick();

    // 5: read-after-write hazard on the buffered line; other lines pass.
    wr_issue(1'b1, 32'h0000_1230, 4'h0,
             {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000});
    dc_rd_req = 1'b1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_1238;
    #1;
    chk("t5_raw_block", dc_rd_rdy, 1'b0);
    dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_2000;
    @(negedge clk);
    chk("t5_other_line", dc_rd_rdy, 1'b1);
    exp_ar.push_back(mk_ax(4'd1, 32'h0000_2000, 8'd3));
    tick(); dc_rd_req = 1'b0;
    ar_accept(0);
    rd_burst(1'b1, 32'hF0, 4, 4);
    dc_rd_req = 1'b1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_1238;
    @(negedge clk);
    chk("t5_raw_block_aw", dc_rd_rdy, 1'b0);
    tick();
    aw_accept();
    w_drain(4, 1'b0);
    @(negedge clk);
    chk("t5_raw_block_resp", dc_rd_rdy, 1'b0);
    tick();
    b_accept(rdy_b);
    chk("t5_raw_block_b", rdy_b, 1'b0);
    @(negedge clk);
    chk("t5_raw_release", dc_rd_rdy, 1'b1);
    exp_ar.push_back(mk_ax(4'd1, 32'h0000_1238, 8'd0));
    tick(); dc_rd_req = 1'b0;
    ar_accept(0);
    rd_burst(1'b1, 32'hE0, 1, 1);

    // 6: asynchronous reset mid R burst with a write also in flight.
    wr_issue(1'b0, 32'h0000_5000, 4'b1001, {96'd0, 32'hCAFE_F00D});
    aw_accept();
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0080;
    exp_ar.push_back(mk_ax(4'd0, 32'h1C00_0080, 8'd3));
    @(negedge clk);
    chk("t6_ic_rdy", ic_rd_rdy, 1'b1);
    tick(); ic_rd_req = 1'b0;
    ar_accept(0);
    rd_burst(1'b0, 32'h90, 2, 4);
    axi.rvalid = 1'b1; axi.rdata = 32'h92; axi.rlast = 1'b0;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C00_00C0;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'd0);
    chk("t6_rst_ret", {ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last}, 4'd0);
    chk("t6_rst_rdy", {ic_rd_rdy, dc_wr_rdy}, 2'b01);
    chk("t6_rst_addr_data", {axi.araddr, axi.awaddr, axi.wdata}, 96'd0);
    exp_w.delete();
    axi.rvalid = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_ic_rdy_after", ic_rd_rdy, 1'b1);
    exp_ar.push_back(mk_ax(4'd0, 32'h1C00_00C0, 8'd3));
    tick(); ic_rd_req = 1'b0;
    ar_accept(1);
    rd_burst(1'b0, 32'h50, 4, 4);
    repeat (2) tick();

    chk("left_ar", exp_ar.size(), 0);
    chk("left_aw", exp_aw.size(), 0);
    chk("left_w", exp_w.size(), 0);
    chk("left_ic", exp_ic.size(), 0);
    chk("left_dc", exp_dc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
